cache_access_sequencer: RTL and testbench

CACHE_ACCESS_SEQUENCER -- requirements
Module: cache_access_sequencer

---
 rtl/cache_access_sequencer_if.sv | 51 +++++
 rtl/cache_access_sequencer.sv | 125 ++++++++++++
 tb/tb_cache_access_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cache_access_sequencer_if.sv
// Bundle between the access sequencer, its two requesters, the cache arrays and the line-fill memory.
// The sequencer connects through slave; the environment side connects through master.
interface cache_access_sequencer_if #(
   parameter int ADDR_W  = 32,
   parameter int BLOCK_W = 256,
   parameter int CNT_W   = 16
);
   logic               req0_valid;
   logic               req1_valid;
   logic               req0_we;
   logic               req1_we;
   logic [ADDR_W-1:0]  req0_pa;
   logic [ADDR_W-1:0]  req1_pa;
   logic [7:0]         req0_wbyte;
   logic [7:0]         req1_wbyte;
   logic               req0_ready;
   logic               req1_ready;
   logic               resp_valid;
   logic               resp_id;
   logic [7:0]         resp_data;
   logic [ADDR_W-1:0]  cache_pa;
   logic [7:0]         cache_wbyte;
   logic               cache_hit;
   logic [7:0]         cache_rdata;
   logic               cache_read;
   logic               cache_write;
   logic               cache_replace;
   logic [BLOCK_W-1:0] cache_block;
   logic               mem_req;
   logic [ADDR_W-6:0]  mem_addr;
   logic               mem_rvalid;
   logic [BLOCK_W-1:0] mem_block;
   logic [CNT_W-1:0]   hit_count;
   logic [CNT_W-1:0]   miss_count;

   modport slave (
      input  req0_valid, req1_valid, req0_we, req1_we, req0_pa, req1_pa,
             req0_wbyte, req1_wbyte, cache_hit, cache_rdata, mem_rvalid, mem_block,
      output req0_ready, req1_ready, resp_valid, resp_id, resp_data, cache_pa,
             cache_wbyte, cache_read, cache_write, cache_replace, cache_block,
             mem_req, mem_addr, hit_count, miss_count
   );

   modport master (
      output req0_valid, req1_valid, req0_we, req1_we, req0_pa, req1_pa,
             req0_wbyte, req1_wbyte, cache_hit, cache_rdata, mem_rvalid, mem_block,
      input  req0_ready, req1_ready, resp_valid, resp_id, resp_data, cache_pa,
             cache_wbyte, cache_read, cache_write, cache_replace, cache_block,
             mem_req, mem_addr, hit_count, miss_count
   );
endinterface

// File: rtl/cache_access_sequencer.sv
// Two-requester byte-access sequencer in front of a single-ported cache: round-robin grant,
// tag lookup, line refill from memory on a miss, one access in flight at a time.
module cache_access_sequencer #(
   parameter int ADDR_W  = 32,
   parameter int BLOCK_W = 256,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   cache_access_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_MISS_WAIT = 3'd2,
      S_FILL      = 3'd3,
      S_ACCESS    = 3'd4,
      S_RESP      = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               r_ptr;
   logic               r_id;
   logic               r_we;
   logic [ADDR_W-1:0]  r_pa;
   logic [7:0]         r_wbyte;
   logic [BLOCK_W-1:0] r_line;
   logic [CNT_W-1:0]   r_hit_cnt;
   logic [CNT_W-1:0]   r_miss_cnt;
   logic               w_grant;
   logic               w_grant_id;

   // Requester 1 wins when it is alone, or when both are pending and the pointer names it.
   always_comb begin
      w_grant_id = bus.req1_valid & (~bus.req0_valid | r_ptr);
      w_grant    = (r_state == S_IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      if (w_grant) w_state_next = S_LOOKUP;
         S_LOOKUP:    w_state_next = bus.cache_hit ? S_ACCESS : S_MISS_WAIT;
         S_MISS_WAIT: if (bus.mem_rvalid) w_state_next = S_FILL;
         S_FILL:      w_state_next = S_ACCESS;
         S_ACCESS:    w_state_next = S_RESP;
         S_RESP:      w_state_next = S_IDLE;
         default:     w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr      <= 1'b0;
         r_id       <= 1'b0;
         r_we       <= 1'b0;
         r_pa       <= '0;
         r_wbyte    <= '0;
         r_line     <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_grant) begin
            r_ptr   <= ~w_grant_id;
            r_id    <= w_grant_id;
            r_we    <= w_grant_id ? bus.req1_we    : bus.req0_we;
            r_pa    <= w_grant_id ? bus.req1_pa    : bus.req0_pa;
            r_wbyte <= w_grant_id ? bus.req1_wbyte : bus.req0_wbyte;
         end
         // Statistics stick at all-ones rather than wrapping.
         if (r_state == S_LOOKUP) begin
            if (bus.cache_hit) begin
               if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end else begin
               if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
         end
         if ((r_state == S_MISS_WAIT) && bus.mem_rvalid) begin
            r_line <= bus.mem_block;
         end
      end
   end

   assign bus.cache_pa    = r_pa;
   assign bus.cache_wbyte = r_wbyte;
   assign bus.mem_addr    = r_pa[ADDR_W-1:5];
   assign bus.cache_block = r_line;
   assign bus.hit_count   = r_hit_cnt;
   assign bus.miss_count  = r_miss_cnt;

   always_comb begin
      bus.req0_ready    = w_grant & ~w_grant_id;
      bus.req1_ready    = w_grant &  w_grant_id;
      bus.mem_req       = 1'b0;
      bus.cache_replace = 1'b0;
      bus.cache_read    = 1'b0;
      bus.cache_write   = 1'b0;
      bus.resp_valid    = 1'b0;
      bus.resp_id       = 1'b0;
      bus.resp_data     = 8'h00;
      case (r_state)
         S_MISS_WAIT: bus.mem_req       = 1'b1;
         S_FILL:      bus.cache_replace = 1'b1;
         S_ACCESS: begin
            bus.cache_write = r_we;
            bus.cache_read  = ~r_we;
         end
         S_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_id    = r_id;
            bus.resp_data  = r_we ? 8'h00 : bus.cache_rdata;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cache_access_sequencer.sv
// Randomized bench for cache_access_sequencer: a transaction-level model predicts grant order,
// per-cycle strobes, response data and saturating statistics for every access.
module tb_cache_access_sequencer;
   localparam int ADDR_W  = 32;
   localparam int BLOCK_W = 256;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;

   cache_access_sequencer_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .CNT_W(CNT_W)) bus ();

   cache_access_sequencer #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_txn = 0;
   int m_ptr = 0;
   int m_hits = 0;
   int m_misses = 0;

   task automatic check(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // {ready0, ready1, cache_read, cache_write, cache_replace, mem_req, resp_valid}
   function automatic logic [6:0] strobes();
      return {bus.req0_ready, bus.req1_ready, bus.cache_read, bus.cache_write,
              bus.cache_replace, bus.mem_req, bus.resp_valid};
   endfunction

   function automatic logic [BLOCK_W-1:0] rand_block();
      logic [BLOCK_W-1:0] b;
      for (int k = 0; k < BLOCK_W / 32; k++) b[k*32 +: 32] = $urandom();
      return b;
   endfunction

   // Called at a falling edge while the DUT is idle; returns one cycle into the next idle period.
   task automatic run_access(input logic v0, input logic v1, input logic we0, input logic we1,
                             input logic [31:0] pa0, input logic [31:0] pa1,
                             input logic [7:0] wb0, input logic [7:0] wb1,
                             input bit hit, input int n, input logic [7:0] rd,
                             input bit junk_rvalid, output int gid);
      logic               we;
      logic [31:0]        pa;
      logic [7:0]         wb;
      logic [BLOCK_W-1:0] blk;
      bus.req0_valid = v0;  bus.req1_valid = v1;
      bus.req0_we    = we0; bus.req1_we    = we1;
      bus.req0_pa    = pa0; bus.req1_pa    = pa1;
      bus.req0_wbyte = wb0; bus.req1_wbyte = wb1;
      gid = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
      we  = (gid == 1) ? we1 : we0;
      pa  = (gid == 1) ? pa1 : pa0;
      wb  = (gid == 1) ? wb1 : wb0;
      #1 check("grant", BLOCK_W'(strobes()), BLOCK_W'((gid == 1) ? 7'b0100000 : 7'b1000000));
      m_ptr = 1 - gid;

      @(negedge clk);
      bus.cache_hit  = hit;
      bus.mem_rvalid = junk_rvalid;
      bus.mem_block  = rand_block();
      #1 check("lookup_strobes", BLOCK_W'(strobes()), '0);
      check("cache_pa", BLOCK_W'(bus.cache_pa), BLOCK_W'(pa));
      if (hit) m_hits   = (m_hits   < CNT_MAX) ? m_hits + 1   : m_hits;
      else     m_misses = (m_misses < CNT_MAX) ? m_misses + 1 : m_misses;

      if (!hit) begin
         blk = rand_block();
         for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.cache_hit  = 1'b1;
            bus.mem_rvalid = (i == n);
            bus.mem_block  = (i == n) ? blk : ~blk;
            #1 check("miss_wait_strobes", BLOCK_W'(strobes()), BLOCK_W'(7'b0000010));
            check("mem_addr", BLOCK_W'(bus.mem_addr), BLOCK_W'(pa[31:5]));
         end
         @(negedge clk);
         bus.mem_rvalid = 1'b1;
         bus.mem_block  = rand_block();
         #1 check("fill_strobes", BLOCK_W'(strobes()), BLOCK_W'(7'b0000100));
         check("cache_block", bus.cache_block, blk);
      end

      @(negedge clk);
      bus.mem_rvalid  = 1'b0;
      bus.cache_hit   = ~hit;
      bus.cache_rdata = ~rd;
      #1 check("access_strobes", BLOCK_W'(strobes()), BLOCK_W'(we ? 7'b0001000 : 7'b0010000));
      check("cache_wbyte", BLOCK_W'(bus.cache_wbyte), BLOCK_W'(wb));

      @(negedge clk);
      bus.cache_rdata = rd;
      #1 check("resp_strobes", BLOCK_W'(strobes()), BLOCK_W'(7'b0000001));
      check("resp_id", BLOCK_W'(bus.resp_id), BLOCK_W'(gid));
      check("resp_data", BLOCK_W'(bus.resp_data), BLOCK_W'(we ? 8'h00 : rd));
      check("hit_count", BLOCK_W'(bus.hit_count), BLOCK_W'(m_hits));
      check("miss_count", BLOCK_W'(bus.miss_count), BLOCK_W'(m_misses));
      n_txn++;
      $display("txn %0d: grant=%0d we=%0d pa=%08h hit=%0d n=%0d data=%02h hits=%0d misses=%0d",
               n_txn, gid, we, pa, hit, n, bus.resp_data, bus.hit_count, bus.miss_count);
      @(negedge clk);
   endtask

   initial begin
      int g;
      reset = 1'b1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      bus.req0_we = 1'b0;    bus.req1_we = 1'b1;
      bus.req0_pa = 32'hDEAD_BEEF; bus.req1_pa = 32'h0BAD_F00D;
      bus.req0_wbyte = 8'h11; bus.req1_wbyte = 8'h22;
      bus.cache_hit = 1'b0; bus.cache_rdata = 8'h00;
      bus.mem_rvalid = 1'b0; bus.mem_block = '0;
      repeat (3) @(negedge clk);
      #1 check("reset_strobes", BLOCK_W'(strobes()), '0);
      check("reset_counts", BLOCK_W'({bus.hit_count, bus.miss_count}), '0);
      check("reset_pa", BLOCK_W'(bus.cache_pa), '0);
      @(negedge clk);
      reset = 1'b0;

      // Read hit, then write miss with a three-cycle refill wait.
      run_access(1, 0, 0, 0, 32'h0000_1234, 32'h0, 8'h00, 8'h00, 1, 0, 8'hA5, 0, g);
      run_access(0, 1, 0, 1, 32'h0, 32'h0000_2040, 8'h00, 8'h3C, 0, 3, 8'h77, 0, g);

      // Continuous tie: pointer alternates the winner.
      for (int i = 0; i < 4; i++) begin
         run_access(1, 1, 1'($urandom()), 1'($urandom()), $urandom(), $urandom(),
                    8'($urandom()), 8'($urandom()), 1'($urandom()), 1, 8'($urandom()), 0, g);
         check("tie_order", BLOCK_W'(g), BLOCK_W'(i % 2));
      end

      // Five hits pin the 2-bit hit counter at its ceiling.
      for (int i = 0; i < 5; i++)
         run_access(1, 0, 0, 0, $urandom(), 32'h0, 8'h00, 8'h00, 1, 0, 8'($urandom()), 0, g);
      check("hit_saturated", BLOCK_W'(bus.hit_count), BLOCK_W'(CNT_MAX));

      // Reset while waiting for a refill: the access vanishes without a response.
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b0; bus.req0_pa = 32'h0000_5560;
      #1 check("pre_reset_grant", BLOCK_W'(strobes()), BLOCK_W'(7'b1000000));
      @(negedge clk); bus.cache_hit = 1'b0;
      @(negedge clk);
      #1 check("pre_reset_mem_req", BLOCK_W'(strobes()), BLOCK_W'(7'b0000010));
      reset = 1'b1;
      @(negedge clk);
      #1 check("mid_reset_strobes", BLOCK_W'(strobes()), '0);
      check("mid_reset_counts", BLOCK_W'({bus.hit_count, bus.miss_count}), '0);
      check("mid_reset_mem_addr", BLOCK_W'(bus.mem_addr), '0);
      reset = 1'b0;
      bus.req0_valid = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_block  = rand_block();
      m_ptr = 0; m_hits = 0; m_misses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.mem_rvalid = (i == 0);
         #1 check("idle_after_reset", BLOCK_W'(strobes()), '0);
      end
      check("post_reset_cache_block", bus.cache_block, '0);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         logic v0, v1;
         v0 = 1'($urandom());
         v1 = v0 ? 1'($urandom()) : 1'b1;
         run_access(v0, v1, 1'($urandom()), 1'($urandom()), $urandom(), $urandom(),
                    8'($urandom()), 8'($urandom()), 1'($urandom()), int'($urandom_range(1, 4)),
                    8'($urandom()), 1'($urandom()), g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
